// File: rtl/encoder83_stream.sv
// encoder83_stream: accepts a multi-hot 8-bit request word and streams out
// the index of each set bit, one per downstream transfer, in priority order
// (highest bit first, or lowest bit first when LSB_FIRST=1).
module encoder83_stream #(
  parameter int LSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_valid,
  input  logic [7:0] req,
  output logic       req_ready,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       last,
  output logic [3:0] count,
  output logic       drop
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic [3:0] count_reg, count_next;
  logic       drop_reg, drop_next;

  logic       accept;
  logic       transfer;
  logic       req_zero;
  logic       single_bit;
  logic [3:0] req_popcount;
  logic [2:0] code_sel;
  logic [7:0] code_mask;

  // Handshake qualifiers; both already include en through ready/valid,
  // and they can never fire together because they belong to different states.
  assign accept   = req_valid & req_ready;
  assign transfer = code_valid & code_ready;
  assign req_zero = (req == 8'h00);

  // Exactly one pending bit: nonzero and clearing the lowest set bit leaves 0.
  assign single_bit = (pending_reg != 8'h00) &&
                      ((pending_reg & (pending_reg - 8'd1)) == 8'h00);

  // Population count of the incoming word, loaded into count on accept.
  always_comb begin
    req_popcount = 4'd0;
    for (int i = 0; i < 8; i++) begin
      req_popcount = req_popcount + 4'(req[i]);
    end
  end

  // Priority select over pending; the later loop iteration wins, so the
  // scan direction decides which end of the word has priority.
  always_comb begin
    code_sel = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_reg[i]) code_sel = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_reg[i]) code_sel = 3'(i);
      end
    end
  end

  // One-hot mask of the line being handed out, used to retire it on transfer.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_code_mask
      assign code_mask[gi] = (code_sel == 3'(gi));
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic: a nonzero accepted word starts emission, the
  // transfer of the final pending line returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && !req_zero) state_next = EMIT;
      EMIT: if (transfer && last)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake flags and the registered drop pulse gated by en.
  always_comb begin
    req_ready  = en & (state_reg == IDLE);
    code_valid = en & (state_reg == EMIT);
    last       = code_valid & single_bit;
    drop       = drop_reg & en;
  end

  // Datapath next values: capture on accept, retire one line on transfer,
  // otherwise hold. drop only ever lasts the cycle after a zero accept.
  always_comb begin
    pending_next = pending_reg;
    count_next   = count_reg;
    drop_next    = 1'b0;
    if (accept) begin
      pending_next = req;
      count_next   = req_popcount;
      drop_next    = req_zero;
    end else if (transfer) begin
      pending_next = pending_reg & ~code_mask;
    end
  end

  // Datapath registers; reset discards any remaining pending lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 8'h00;
      count_reg   <= 4'd0;
      drop_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
      drop_reg    <= drop_next;
    end
  end

  assign code  = code_sel;
  assign count = count_reg;

endmodule
